// File: rtl/return_addr_stack.sv
// Return-address stack for the fetch stage: circular LIFO fed by the jump
// controller's JSB/RET strobes, with combinational top-of-stack read.
module return_addr_stack #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_stack,
  input  logic                  pop_stack,
  input  logic [ADDR_WIDTH-1:0] push_data,
  output logic [ADDR_WIDTH-1:0] stack_out,
  output logic                  empty,
  output logic                  full,
  output logic [PTR_WIDTH:0]    count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [PTR_WIDTH:0]   DepthCnt = (PTR_WIDTH + 1)'(DEPTH);
  localparam logic [PTR_WIDTH-1:0] PtrOne   = PTR_WIDTH'(1);
  localparam logic [PTR_WIDTH:0]   CntOne   = (PTR_WIDTH + 1)'(1);

  logic [ADDR_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_WIDTH-1:0]  tp_q, tp_d;
  logic [PTR_WIDTH:0]    count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic is_empty, is_full;
  logic [PTR_WIDTH-1:0] tp_inc, tp_dec;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DepthCnt);
  assign tp_inc   = tp_q + PtrOne;
  assign tp_dec   = tp_q - PtrOne;

  always_comb begin
    mem_d       = mem_q;
    tp_d        = tp_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    unique case ({push_stack, pop_stack})
      2'b10: begin
        mem_d[tp_inc] = push_data;
        tp_d          = tp_inc;
        // When full the oldest entry is overwritten and count saturates.
        if (is_full) begin
          overflow_d = 1'b1;
        end else begin
          count_d = count_q + CntOne;
        end
      end
      2'b01: begin
        if (is_empty) begin
          underflow_d = 1'b1;
        end else begin
          tp_d    = tp_dec;
          count_d = count_q - CntOne;
        end
      end
      2'b11: begin
        // Replace on a non-empty stack; on an empty stack it is a plain push.
        if (is_empty) begin
          mem_d[tp_inc] = push_data;
          tp_d          = tp_inc;
          count_d       = CntOne;
        end else begin
          mem_d[tp_q] = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      tp_q        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      tp_q        <= tp_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign stack_out = is_empty ? '0 : mem_q[tp_q];
  assign empty     = is_empty;
  assign full      = is_full;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_return_addr_stack.sv
// Scoreboard bench for return_addr_stack: a queue-based LIFO model predicts the
// outputs of every cycle; a negedge monitor compares them against the DUT.
module tb_return_addr_stack;

  localparam int AW    = 12;
  localparam int DEPTH = 4;
  localparam int PW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          push_stack, pop_stack;
  logic [AW-1:0] push_data;
  logic [AW-1:0] stack_out;
  logic          empty, full, overflow, underflow;
  logic [PW:0]   count;

  return_addr_stack #(
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .push_stack(push_stack),
    .pop_stack (pop_stack),
    .push_data (push_data),
    .stack_out (stack_out),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] so;
    logic [PW:0]   cnt;
    logic          e;
    logic          f;
    logic          ov;
    logic          uf;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] stk[$];
  bit            m_ov, m_uf;
  bit            armed = 0;
  int            total = 0;
  int            bad   = 0;
  int            step_no = 0;

  function automatic exp_t model_out();
    exp_t x;
    x.so  = (stk.size() == 0) ? '0 : stk[stk.size()-1];
    x.cnt = (PW + 1)'(stk.size());
    x.e   = (stk.size() == 0);
    x.f   = (stk.size() == DEPTH);
    x.ov  = m_ov;
    x.uf  = m_uf;
    return x;
  endfunction

  task automatic model_apply(input bit r, input bit p, input bit o, input logic [AW-1:0] d);
    if (r) begin
      stk.delete();
      m_ov = 0;
      m_uf = 0;
    end else if (p && o) begin
      if (stk.size() == 0) stk.push_back(d);
      else stk[stk.size()-1] = d;
    end else if (p) begin
      if (stk.size() == DEPTH) begin
        void'(stk.pop_front());
        m_ov = 1;
      end
      stk.push_back(d);
    end else if (o) begin
      if (stk.size() == 0) m_uf = 1;
      else void'(stk.pop_back());
    end
  endtask

  // Drive one cycle of stimulus; the expected outputs for this cycle are the
  // model's state before the operation takes effect.
  task automatic step(input bit r, input bit p, input bit o, input logic [AW-1:0] d);
    @(posedge clk);
    #1;
    rst        = r;
    push_stack = p;
    pop_stack  = o;
    push_data  = d;
    if (armed) sb.push_back(model_out());
    model_apply(r, p, o, d);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e, a;
      e = sb.pop_front();
      a = '{so: stack_out, cnt: count, e: empty, f: full, ov: overflow, uf: underflow};
      total++;
      step_no++;
      if (a !== e) begin
        bad++;
        $display("FAIL cycle%0d: got so=%h cnt=%0d e=%b f=%b ov=%b uf=%b want so=%h cnt=%0d e=%b f=%b ov=%b uf=%b",
                 step_no, a.so, a.cnt, a.e, a.f, a.ov, a.uf,
                 e.so, e.cnt, e.e, e.f, e.ov, e.uf);
      end
    end
  end

  initial begin
    rst = 1'b1; push_stack = 1'b0; pop_stack = 1'b0; push_data = '0;
    step(1, 0, 0, '0);
    armed = 1;
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);

    // Nested calls
    step(0, 1, 0, 12'h010);
    step(0, 1, 0, 12'h020);
    step(0, 1, 0, 12'h030);
    repeat (3) step(0, 0, 1, '0);
    step(0, 0, 0, '0);

    // Overflow wrap
    for (int i = 1; i <= 5; i++) step(0, 1, 0, AW'(i));
    repeat (4) step(0, 0, 1, '0);
    step(0, 0, 0, '0);

    // Underflow, sticky across a later push
    step(1, 0, 0, '0);
    step(0, 0, 1, '0);
    step(0, 1, 0, 12'h0AA);
    step(0, 0, 0, '0);

    // Replace on non-empty and on empty
    step(1, 0, 0, '0);
    step(0, 1, 0, 12'h100);
    step(0, 1, 0, 12'h200);
    step(0, 1, 1, 12'h2FF);
    step(0, 0, 1, '0);
    step(0, 0, 1, '0);
    step(0, 1, 1, 12'h055);
    step(0, 0, 0, '0);

    // Reset mid-operation discards the push
    step(0, 1, 0, 12'h111);
    step(0, 1, 0, 12'h222);
    step(1, 1, 0, 12'h777);
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int unsigned sel;
      sel = $urandom_range(0, 99);
      if (sel < 2)       step(1, 0, 0, '0);
      else if (sel < 42) step(0, 1, 0, AW'($urandom));
      else if (sel < 78) step(0, 0, 1, '0);
      else if (sel < 90) step(0, 1, 1, AW'($urandom));
      else               step(0, 0, 0, '0);
    end
    step(0, 0, 0, '0);

    begin
      int guard = 0;
      while (sb.size() != 0 && guard < 20) begin
        @(posedge clk);
        guard++;
      end
      if (sb.size() != 0) begin
        total++;
        bad++;
        $display("FAIL drain: got %0d pending entries want 0", sb.size());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
